// File: rtl/alu_z_drain_if.sv
// Handshake bundle between the ALU, the Z drain stage and the CPU bus.
// With ZFLAGS_EN defined the bundle also carries the z_zero / z_neg result flags.
interface alu_z_drain_if #(
    parameter int unsigned DW = 32
) ();
    logic [DW-1:0] alu_lo;
    logic [DW-1:0] alu_hi;
    logic          alu_wide;
    logic          alu_valid;
    logic          alu_ready;
    logic [DW-1:0] bus_data;
    logic          bus_valid;
    logic          bus_sel;
    logic          bus_ready;
    logic          busy;
`ifdef ZFLAGS_EN
    logic          z_zero;
    logic          z_neg;

    modport master (
        output alu_lo, alu_hi, alu_wide, alu_valid, bus_ready,
        input  alu_ready, bus_data, bus_valid, bus_sel, busy, z_zero, z_neg
    );
    modport slave (
        input  alu_lo, alu_hi, alu_wide, alu_valid, bus_ready,
        output alu_ready, bus_data, bus_valid, bus_sel, busy, z_zero, z_neg
    );
`else
    modport master (
        output alu_lo, alu_hi, alu_wide, alu_valid, bus_ready,
        input  alu_ready, bus_data, bus_valid, bus_sel, busy
    );
    modport slave (
        input  alu_lo, alu_hi, alu_wide, alu_valid, bus_ready,
        output alu_ready, bus_data, bus_valid, bus_sel, busy
    );
`endif
endinterface

// File: rtl/alu_z_drain.sv
// Z result stage: captures one ALU result into ZHigh:ZLow and drains it as one or two bus beats.
// Optional ZFLAGS_EN adds registered zero/negative flags of the captured result.
module alu_z_drain #(
    parameter int unsigned DW     = 32,
    parameter bit          HI_SEL = 1'b1
) (
    input  logic         i_clock,
    input  logic         i_clear,
    alu_z_drain_if.slave z_if
);

    typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

    state_e        r_state;
    state_e        w_state_d;
    logic [DW-1:0] r_zlo;
    logic [DW-1:0] r_zhi;
    logic          r_wide;
    logic          w_ready;
    logic          w_accept;

    // Ready also rises while the final beat completes so a new result can follow with no gap.
    always_comb begin
        w_ready   = 1'b0;
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                w_ready = 1'b1;
            end
            StLow: begin
                w_ready = ~r_wide & z_if.bus_ready;
            end
            StHigh: begin
                w_ready = z_if.bus_ready;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
        w_accept = z_if.alu_valid & w_ready;

        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_d = StLow;
            end
            StLow: begin
                if (z_if.bus_ready) begin
                    if (r_wide)        w_state_d = StHigh;
                    else if (w_accept) w_state_d = StLow;
                    else               w_state_d = StIdle;
                end
            end
            StHigh: begin
                if (z_if.bus_ready) w_state_d = w_accept ? StLow : StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        z_if.alu_ready = w_ready;
        z_if.bus_valid = (r_state != StIdle);
        z_if.busy      = (r_state != StIdle);
        z_if.bus_data  = '0;
        z_if.bus_sel   = 1'b0;
        if (r_state == StLow) begin
            z_if.bus_data = r_zlo;
            z_if.bus_sel  = ~HI_SEL;
        end else if (r_state == StHigh) begin
            z_if.bus_data = r_zhi;
            z_if.bus_sel  = HI_SEL;
        end
    end

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_state <= StIdle;
            r_zlo   <= '0;
            r_zhi   <= '0;
            r_wide  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_zlo  <= z_if.alu_lo;
                r_zhi  <= z_if.alu_wide ? z_if.alu_hi : '0;
                r_wide <= z_if.alu_wide;
            end
        end
    end

`ifdef ZFLAGS_EN
    logic r_zero;
    logic r_neg;

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_accept) begin
            r_zero <= (z_if.alu_lo == '0) & (~z_if.alu_wide | (z_if.alu_hi == '0));
            r_neg  <= z_if.alu_wide ? z_if.alu_hi[DW-1] : z_if.alu_lo[DW-1];
        end
    end

    assign z_if.z_zero = r_zero;
    assign z_if.z_neg  = r_neg;
`endif

endmodule

// File: tb/tb_alu_z_drain.sv
// Directed bench for alu_z_drain: a scoreboard queue of expected beats plus inline state checks.
module tb_alu_z_drain;

    localparam int unsigned DW = 32;
    localparam bit          HI = 1'b1;

    typedef struct packed {
        logic [31:0] data;
        logic        sel;
    } beat_t;

    logic  clk;
    logic  clear;
    int    checks;
    int    failures;
    int    cyc;
    beat_t exp_q[$];
    int    beat_log[$];

    alu_z_drain_if #(.DW(DW)) bus_if ();

    alu_z_drain #(.DW(DW), .HI_SEL(HI)) dut (
        .i_clock (clk),
        .i_clear (clear),
        .z_if    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every consumed beat is compared against the oldest expected beat.
    always @(negedge clk) begin
        if (!clear && bus_if.bus_valid === 1'b1 && bus_if.bus_ready === 1'b1) begin
            beat_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_beat observed=%h expected=none", bus_if.bus_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", bus_if.bus_data, e.data);
                chk("beat_sel", {31'd0, bus_if.bus_sel}, {31'd0, e.sel});
            end
        end
    end

    // Present a result, queue its beats, return just after the accepting edge.
    task automatic send(input logic [31:0] lo, input logic [31:0] hi, input logic wide);
        int n;
        bus_if.alu_lo    = lo;
        bus_if.alu_hi    = hi;
        bus_if.alu_wide  = wide;
        bus_if.alu_valid = 1'b1;
        exp_q.push_back('{data: lo, sel: ~HI});
        if (wide) exp_q.push_back('{data: hi, sel: HI});
        n = 0;
        forever begin
            @(negedge clk);
            if (bus_if.alu_ready === 1'b1) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $error("FAIL accept_timeout observed=no_ready expected=ready");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        bus_if.alu_valid = 1'b0;
    endtask

    initial begin
        int idx;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        clear    = 1'b1;
        bus_if.alu_lo    = '0;
        bus_if.alu_hi    = '0;
        bus_if.alu_wide  = 1'b0;
        bus_if.alu_valid = 1'b0;
        bus_if.bus_ready = 1'b0;
        #2;
        chk("rst_bus_valid", {31'd0, bus_if.bus_valid}, 32'd0);
        chk("rst_bus_data", bus_if.bus_data, 32'd0);
        chk("rst_bus_sel", {31'd0, bus_if.bus_sel}, 32'd0);
        chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("rst_alu_ready", {31'd0, bus_if.alu_ready}, 32'd1);
        @(posedge clk);
        #1;
        clear = 1'b0;

        // Narrow result: one low beat then idle.
        bus_if.bus_ready = 1'b1;
        send(32'hF000_0000, 32'hDEAD_BEEF, 1'b0);
        drop();
        @(negedge clk);
        chk("t1_valid", {31'd0, bus_if.bus_valid}, 32'd1);
        chk("t1_data", bus_if.bus_data, 32'hF000_0000);
        chk("t1_busy", {31'd0, bus_if.busy}, 32'd1);
        chk("t1_zhigh_zero", dut.r_zhi, 32'd0);
`ifdef ZFLAGS_EN
        chk("t1_z_neg", {31'd0, bus_if.z_neg}, 32'd1);
        chk("t1_z_zero", {31'd0, bus_if.z_zero}, 32'd0);
`endif
        @(negedge clk);
        chk("t1_idle_valid", {31'd0, bus_if.bus_valid}, 32'd0);
        chk("t1_idle_data", bus_if.bus_data, 32'd0);
        @(posedge clk);
        #1;

        // Wide result with bus stalled three cycles.
        bus_if.bus_ready = 1'b0;
        send(32'h2345_6789, 32'h0000_0001, 1'b1);
        drop();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_stall_data", bus_if.bus_data, 32'h2345_6789);
            chk("t2_stall_sel", {31'd0, bus_if.bus_sel}, 32'd0);
            chk("t2_stall_ready", {31'd0, bus_if.alu_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus_if.bus_ready = 1'b1;
        @(negedge clk);
        chk("t2_low_data", bus_if.bus_data, 32'h2345_6789);
        chk("t2_low_ready", {31'd0, bus_if.alu_ready}, 32'd0);
        @(negedge clk);
        chk("t2_high_data", bus_if.bus_data, 32'h0000_0001);
        chk("t2_high_sel", {31'd0, bus_if.bus_sel}, 32'd1);
        chk("t2_high_ready", {31'd0, bus_if.alu_ready}, 32'd1);
        @(negedge clk);
        chk("t2_idle", {31'd0, bus_if.bus_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back narrow results on consecutive cycles.
        idx = beat_log.size();
        send(32'd1, 32'd0, 1'b0);
        send(32'd2, 32'd0, 1'b0);
        send(32'd3, 32'd0, 1'b0);
        drop();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t3_beat_count", beat_log.size() - idx, 32'd3);
        if (beat_log.size() >= idx + 3)
            chk("t3_no_gap", beat_log[idx+2] - beat_log[idx], 32'd2);
        @(posedge clk);
        #1;

        // Clear while the high beat is stalled.
        bus_if.bus_ready = 1'b0;
        send(32'hAAAA_0000, 32'h0000_5555, 1'b1);
        drop();
        bus_if.bus_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.bus_ready = 1'b0;
        @(negedge clk);
        chk("t4_in_high", bus_if.bus_data, 32'h0000_5555);
        #2;
        clear = 1'b1;
        #1;
        chk("t4_clr_valid", {31'd0, bus_if.bus_valid}, 32'd0);
        chk("t4_clr_data", bus_if.bus_data, 32'd0);
        chk("t4_clr_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("t4_clr_sel", {31'd0, bus_if.bus_sel}, 32'd0);
        chk("t4_clr_ready", {31'd0, bus_if.alu_ready}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus_if.bus_ready = 1'b1;
        @(negedge clk);
        chk("t4_no_resend", {31'd0, bus_if.bus_valid}, 32'd0);
        @(posedge clk);
        #1;
        send(32'h0000_0077, 32'd0, 1'b0);
        drop();
        @(negedge clk);
        chk("t4_next_data", bus_if.bus_data, 32'h0000_0077);
        @(posedge clk);
        #1;

        // New data offered while a low beat is held: must be ignored until ready.
        bus_if.bus_ready = 1'b0;
        send(32'h1111_1111, 32'd0, 1'b0);
        bus_if.alu_lo = 32'h9999_9999;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_held_data", bus_if.bus_data, 32'h1111_1111);
            chk("t5_not_ready", {31'd0, bus_if.alu_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus_if.bus_ready = 1'b1;
        send(32'h9999_9999, 32'd0, 1'b0);
        drop();
        @(negedge clk);
        chk("t5_new_data", bus_if.bus_data, 32'h9999_9999);
        @(posedge clk);
        #1;

        // Zero flag behaviour and ZHigh forced to 0 on narrow results.
        send(32'd0, 32'h0000_0001, 1'b1);
        drop();
        @(negedge clk);
`ifdef ZFLAGS_EN
        chk("t6_wide_z_zero", {31'd0, bus_if.z_zero}, 32'd0);
`endif
        chk("t6_wide_zhigh", dut.r_zhi, 32'h0000_0001);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        send(32'd0, 32'hFFFF_FFFF, 1'b0);
        drop();
        @(negedge clk);
`ifdef ZFLAGS_EN
        chk("t6_narrow_z_zero", {31'd0, bus_if.z_zero}, 32'd1);
`endif
        chk("t6_narrow_zhigh", dut.r_zhi, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 32'd0);
        chk("final_idle", {31'd0, bus_if.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
